// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master for the timer register block
// Optional transfer abort when PREADY stalls too long: define APB_ARB_TIMEOUT_EN.

module apb_master_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              grant,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_owner;
  logic   any_req;
  logic   pick;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] tcnt;
`endif

  // On a tie the requester that did not complete last goes next.
  always_comb begin
    any_req = |req_valid;
    pick    = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      pick = ~last_owner;
    end else begin
      pick = req_valid[1];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '1;
      PWDATA     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      grant     <= 2'b00;
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= pick;
            PADDR   <= pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            PWDATA  <= pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
            PWRITE  <= pick ? req_write[1] : req_write[0];
            grant   <= pick ? 2'b10 : 2'b01;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata  <= PWRITE ? '0 : PRDATA;
            rsp_err    <= PSLVERR;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWDATA     <= '0;
            last_owner <= owner;
            state      <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // The cycle that would bring the stall count to TIMEOUT ends the transfer.
          else if (tcnt == CW'(TIMEOUT - 1)) begin
            rsp_rdata  <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWDATA     <= '0;
            last_owner <= owner;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed vector bench for apb_master_arb
// Covers the APB_ARB_TIMEOUT_EN build as well when the macro is defined.

module tb_apb_master_arb;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  grant;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [7:0]  PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  PRDATA;

  int tests = 0;
  int fails = 0;

  apb_master_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] write;
    logic [7:0] a0, a1, d0, d1;
    int         w;
    logic [7:0] prdata;
    logic       slverr;
    logic       exp_owner;
    logic [7:0] exp_paddr, exp_pwdata;
    logic       exp_pwrite;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input vec_t v);
    logic [1:0] og;
    og = v.exp_owner ? 2'b10 : 2'b01;
    req_valid = v.valid;
    req_write = v.write;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    tick;
    chk("grant", {30'd0, grant}, {30'd0, og});
    chk("setup_ctrl", {30'd0, PSEL, PENABLE}, 32'h2);
    chk("setup_fields", {15'd0, PWRITE, PADDR, PWDATA}, {15'd0, v.exp_pwrite, v.exp_paddr, v.exp_pwdata});
    req_valid = 2'b00;
    PRDATA    = v.prdata;
    PSLVERR   = v.slverr;
    PREADY    = (v.w == 0);
    tick;
    chk("access_ctrl", {28'd0, grant, PSEL, PENABLE}, 32'h3);
    for (int k = 1; k <= v.w; k++) begin
      tick;
      chk("wait_hold", {13'd0, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
          {13'd0, 2'b00, 1'b1, 1'b1, v.exp_pwrite, v.exp_paddr, v.exp_pwdata});
      PREADY = (k == v.w);
    end
    tick;
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, og});
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("done_ctrl", {12'd0, grant, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
        {12'd0, 2'b00, 1'b0, 1'b0, v.exp_pwrite, v.exp_paddr, 8'h00});
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    tick;
    chk("rsp_pulse", {28'd0, rsp_valid, grant}, 32'h0);
  endtask

  initial begin
    int n_grant;
    int order[4];
    logic got;

    vecs[0] = '{2'b01, 2'b01, 8'h00, 8'h00, 8'h5A, 8'h00, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 8'h00, 8'h03, 8'h00, 8'h00, 3, 8'hA5, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{2'b01, 2'b01, 8'h01, 8'h00, 8'h3C, 8'h00, 0, 8'h77, 1'b1, 1'b0, 8'h01, 8'h3C, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{2'b01, 2'b01, 8'h02, 8'h00, 8'h11, 8'h00, 0, 8'h77, 1'b0, 1'b0, 8'h02, 8'h11, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{2'b11, 2'b01, 8'h10, 8'h20, 8'hAA, 8'hBB, 1, 8'h5C, 1'b0, 1'b1, 8'h20, 8'hBB, 1'b0, 8'h5C, 1'b0};
    vecs[5] = '{2'b11, 2'b10, 8'h30, 8'h40, 8'hCC, 8'hDD, 2, 8'hE7, 1'b0, 1'b0, 8'h30, 8'hCC, 1'b0, 8'hE7, 1'b0};
    vecs[6] = '{2'b10, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h81, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h81, 1'b1};

    PRESET = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
    tick;
    tick;
    chk("reset_state", {2'd0, grant, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
        {2'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00});
    PRESET = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) xfer(vecs[i]);

    // Fairness: both requesters keep asking; last owner was requester 1.
    n_grant = 0;
    req_valid = 2'b11; req_write = 2'b11; req_addr = 16'h0201; req_wdata = 16'h2211;
    PREADY = 1'b1; PSLVERR = 1'b0;
    for (int c = 0; c < 30 && n_grant < 4; c++) begin
      tick;
      if (grant != 2'b00) begin
        chk("fair_onehot", {31'd0, $onehot(grant)}, 32'd1);
        chk("fair_no_overlap", {30'd0, rsp_valid}, 32'd0);
        order[n_grant] = grant[1] ? 1 : 0;
        n_grant++;
      end
    end
    req_valid = 2'b00;
    chk("fair_count", n_grant, 4);
    for (int i = 0; i < 4; i++) chk("fair_order", order[i], i % 2);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      got = (rsp_valid != 2'b00);
    end
    chk("fair_drain", {31'd0, got}, 32'd1);
    PREADY = 1'b0;
    tick;

    // Reset mid-transfer, with PREADY high in the reset cycle.
    xfer(vecs[0]);
    req_valid = 2'b10; req_write = 2'b00; req_addr = 16'h0300; req_wdata = 16'h0000;
    tick;
    chk("rst_pre_grant", {30'd0, grant}, 32'h2);
    req_valid = 2'b00;
    tick;
    tick;
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 8'h99;
    tick;
    chk("rst_mid", {2'd0, grant, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
        {2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00});
    PRESET = 1'b0; PREADY = 1'b0;
    req_valid = 2'b11;
    tick;
    chk("rst_grant0", {30'd0, rsp_valid == 2'b00, grant == 2'b01}, 32'h3);
    req_valid = 2'b00; PREADY = 1'b1;
    tick;
    tick;
    chk("rst_rsp0", {30'd0, rsp_valid}, 32'h1);
    PREADY = 1'b0;
    tick;

    // Stuck PREADY.
    req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0002; PRDATA = 8'h5F; PSLVERR = 1'b0;
    tick;
    req_valid = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    n_grant = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      if (PENABLE) n_grant++;
      got = (rsp_valid != 2'b00);
    end
    chk("to_seen", {31'd0, got}, 32'd1);
    chk("to_access_cycles", n_grant, 4);
    chk("to_rsp", {22'd0, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE},
        {22'd0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0});
    tick;
`else
    n_grant = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (PENABLE && PSEL && rsp_valid == 2'b00) n_grant++;
    end
    chk("stall_held", n_grant, 20);
    PREADY = 1'b1;
    tick;
    chk("stall_rsp", {21'd0, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE},
        {21'd0, 2'b01, 8'h5F, 1'b0, 1'b0, 1'b0});
    PREADY = 1'b0;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
